// File: rtl/memc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memc_pkg
// Purpose  : Shared types and helpers for the multi-port memory controller.
//            Holds the channel-id width helper and the read-tag layout.
// Ports    : (package - none)
// Revision : 1.0 - initial release
// ============================================================================
package memc_pkg;

    // Largest supported channel count and the id width that covers it.
    // The tag is sized for the largest case so one struct serves every
    // NUM_CH; smaller configurations zero-extend their id into it.
    localparam int MAX_CH   = 8;
    localparam int TAG_ID_W = 3;

    // One read-tag pipeline stage: a valid flag plus the originating channel.
    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } memc_tag_t;

    localparam int TAG_W = $bits(memc_tag_t);

    // Channel-id width. A single channel still needs a 1-bit pointer.
    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/memc_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memc_rr_arbiter
// Purpose  : Combinational round-robin arbiter. Searches req_i starting at
//            ptr_i and wrapping modulo NUM_CH; grants the first requester.
// Ports    : req_i       - per-channel request
//            ptr_i       - priority pointer (channel searched first)
//            gnt_o       - one-hot grant
//            gnt_id_o    - encoded index of the granted channel
//            gnt_valid_o - a grant was issued this cycle
// Revision : 1.0 - initial release
// ============================================================================
module memc_rr_arbiter
    import memc_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CH_W   = 1
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [CH_W-1:0]   gnt_id_o,
    output logic              gnt_valid_o
);

    always_comb begin
        int  w_idx;
        logic w_found;
        gnt_o       = '0;
        gnt_id_o    = '0;
        w_found     = 1'b0;
        w_idx       = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            // ptr_i is always < NUM_CH, so one subtraction performs the wrap.
            w_idx = int'(ptr_i) + i;
            if (w_idx >= NUM_CH) begin
                w_idx = w_idx - NUM_CH;
            end
            if (!w_found && req_i[w_idx]) begin
                w_found        = 1'b1;
                gnt_o[w_idx]   = 1'b1;
                gnt_id_o       = CH_W'(w_idx);
            end
        end
        gnt_valid_o = w_found;
    end

endmodule
`default_nettype wire

// File: rtl/memc_multiport.sv
`default_nettype none
// ============================================================================
// Module   : memc_multiport
// Purpose  : N-channel controller for a single-port synchronous block RAM.
//            Round-robin arbitration, one registered RAM command per cycle,
//            and a tag pipeline that steers returning read data to the
//            requesting channel.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            ch_req/ch_we         - per-channel request and write flag
//            ch_addr/ch_wr_data   - packed per-channel address / write data
//            ch_gnt               - one-hot combinational grant
//            ch_rd_valid          - one-hot read-data valid
//            ch_rd_data           - shared read data (bram_rd_data)
//            bram_*               - registered RAM command / RAM read data
// Revision : 1.0 - initial release
// ============================================================================
module memc_multiport
    import memc_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_CH     = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            ch_req,
    input  logic [NUM_CH-1:0]            ch_we,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wr_data,
    output logic [NUM_CH-1:0]            ch_gnt,
    output logic [NUM_CH-1:0]            ch_rd_valid,
    output logic [DATA_WIDTH-1:0]        ch_rd_data,
    output logic                         bram_en,
    output logic                         bram_we,
    output logic [ADDR_WIDTH-1:0]        bram_addr,
    output logic [DATA_WIDTH-1:0]        bram_wr_data,
    input  logic [DATA_WIDTH-1:0]        bram_rd_data
);

    localparam int              CH_W    = ch_w(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    logic [NUM_CH-1:0]     w_req_eff;
    logic [CH_W-1:0]       r_ptr_q;
    logic [CH_W-1:0]       w_ptr_d;
    logic [CH_W-1:0]       w_gnt_id;
    logic                  w_gnt_valid;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    memc_tag_t             w_tag_d;
    memc_tag_t             r_tag_q [RD_LATENCY+1];

    // Grants are suppressed while reset is high so nothing is accepted
    // that the reset is about to discard.
    assign w_req_eff = reset ? '0 : ch_req;

    memc_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req_i       (w_req_eff),
        .ptr_i       (r_ptr_q),
        .gnt_o       (ch_gnt),
        .gnt_id_o    (w_gnt_id),
        .gnt_valid_o (w_gnt_valid)
    );

    // Pointer moves to the channel after the winner; held when idle.
    always_comb begin
        w_ptr_d = r_ptr_q;
        if (w_gnt_valid) begin
            w_ptr_d = (w_gnt_id == LAST_CH) ? '0 : w_gnt_id + CH_W'(1);
        end
    end

    // Select the granted channel's command fields.
    always_comb begin
        w_sel_we   = 1'b0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_gnt_id == CH_W'(k)) begin
                w_sel_we   = ch_we[k];
                w_sel_addr = ch_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data = ch_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Only reads get a tag; writes are acknowledged by the grant alone.
    always_comb begin
        w_tag_d       = '0;
        w_tag_d.valid = w_gnt_valid & ~w_sel_we;
        w_tag_d.id    = TAG_ID_W'(w_gnt_id);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr_q      <= '0;
            bram_en      <= 1'b0;
            bram_we      <= 1'b0;
            bram_addr    <= '0;
            bram_wr_data <= '0;
            for (int s = 0; s <= RD_LATENCY; s++) begin
                r_tag_q[s] <= '0;
            end
        end else begin
            r_ptr_q <= w_ptr_d;
            bram_en <= w_gnt_valid;
            bram_we <= w_gnt_valid & w_sel_we;
            if (w_gnt_valid) begin
                bram_addr    <= w_sel_addr;
                bram_wr_data <= w_sel_data;
            end
            // Stage 0 lines up with bram_en; the last stage lines up with
            // the RAM's read data RD_LATENCY cycles later.
            r_tag_q[0] <= w_tag_d;
            for (int s = 1; s <= RD_LATENCY; s++) begin
                r_tag_q[s] <= r_tag_q[s-1];
            end
        end
    end

    always_comb begin
        ch_rd_valid = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_rd_valid[k] = !reset && r_tag_q[RD_LATENCY].valid &&
                             (r_tag_q[RD_LATENCY].id == TAG_ID_W'(k));
        end
    end

    assign ch_rd_data = bram_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_memc_multiport.sv
`default_nettype none
// ============================================================================
// Module   : tb_memc_multiport
// Purpose  : Directed self-checking bench for memc_multiport with four
//            channels and a two-cycle RAM model.
// Ports    : (testbench - none)
// Revision : 1.0 - initial release
// ============================================================================
module tb_memc_multiport;

    localparam int DW  = 8;
    localparam int AW  = 12;
    localparam int NCH = 4;
    localparam int RDL = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    ch_req;
    logic [NCH-1:0]    ch_we;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*DW-1:0] ch_wr_data;
    logic [NCH-1:0]    ch_gnt;
    logic [NCH-1:0]    ch_rd_valid;
    logic [DW-1:0]     ch_rd_data;
    logic              bram_en;
    logic              bram_we;
    logic [AW-1:0]     bram_addr;
    logic [DW-1:0]     bram_wr_data;
    logic [DW-1:0]     bram_rd_data;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    memc_multiport #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_CH     (NCH),
        .RD_LATENCY (RDL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ch_req       (ch_req),
        .ch_we        (ch_we),
        .ch_addr      (ch_addr),
        .ch_wr_data   (ch_wr_data),
        .ch_gnt       (ch_gnt),
        .ch_rd_valid  (ch_rd_valid),
        .ch_rd_data   (ch_rd_data),
        .bram_en      (bram_en),
        .bram_we      (bram_we),
        .bram_addr    (bram_addr),
        .bram_wr_data (bram_wr_data),
        .bram_rd_data (bram_rd_data)
    );

    // Single-port RAM model: read data appears RDL cycles after the
    // sampled enable; a write is visible to a read issued the next cycle.
    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe [0:RDL-1];

    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_wr_data;
            else         rd_pipe[0]     <= mem[bram_addr];
        end
        for (int s = 1; s < RDL; s++) rd_pipe[s] <= rd_pipe[s-1];
    end
    assign bram_rd_data = rd_pipe[RDL-1];

    task automatic set_ch(input int k, input logic req, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        ch_req[k]             = req;
        ch_we[k]              = we;
        ch_addr[k*AW +: AW]   = a;
        ch_wr_data[k*DW +: DW] = d;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        ch_req = 4'hF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            checks++;
            if (ch_gnt !== 4'b0000) $display("FAIL reset_gnt: got %b expected %b", ch_gnt, 4'b0000);
            else passed++;
            checks++;
            if (bram_en !== 1'b0) $display("FAIL reset_bram_en: got %b expected 0", bram_en);
            else passed++;
            checks++;
            if (ch_rd_valid !== 4'b0000) $display("FAIL reset_rd_valid: got %b expected 0000", ch_rd_valid);
            else passed++;
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (ch_gnt !== 4'b0001) $display("FAIL reset_first_gnt: got %b expected %b", ch_gnt, 4'b0001);
        else passed++;
        ch_req = '0;
    endtask

    task automatic test_single_read;
        @(negedge clk);
        set_ch(1, 1'b1, 1'b1, 12'h123, 8'h5A);
        #1;
        checks++;
        if (ch_gnt !== 4'b0010) $display("FAIL single_wr_gnt: got %b expected %b", ch_gnt, 4'b0010);
        else passed++;
        @(negedge clk);
        checks++;
        if ({bram_en, bram_we, bram_addr, bram_wr_data} !== {1'b1, 1'b1, 12'h123, 8'h5A})
            $display("FAIL single_wr_cmd: got en=%b we=%b addr=%h data=%h expected en=1 we=1 addr=123 data=5a",
                     bram_en, bram_we, bram_addr, bram_wr_data);
        else passed++;
        set_ch(1, 1'b1, 1'b0, 12'h123, 8'h00);
        #1;
        checks++;
        if (ch_gnt !== 4'b0010) $display("FAIL single_rd_gnt: got %b expected %b", ch_gnt, 4'b0010);
        else passed++;
        @(negedge clk);
        ch_req = '0;
        checks++;
        if ({bram_en, bram_we, bram_addr} !== {1'b1, 1'b0, 12'h123})
            $display("FAIL single_rd_cmd: got en=%b we=%b addr=%h expected en=1 we=0 addr=123",
                     bram_en, bram_we, bram_addr);
        else passed++;
        @(negedge clk);
        checks++;
        if (ch_rd_valid !== 4'b0000) $display("FAIL single_rd_early: got %b expected 0000", ch_rd_valid);
        else passed++;
        @(negedge clk);
        checks++;
        if (ch_rd_valid !== 4'b0010 || ch_rd_data !== 8'h5A)
            $display("FAIL single_rd_resp: got valid=%b data=%h expected valid=0010 data=5a", ch_rd_valid, ch_rd_data);
        else passed++;
        @(negedge clk);
        checks++;
        if (ch_rd_valid !== 4'b0000 || bram_en !== 1'b0)
            $display("FAIL single_rd_after: got valid=%b en=%b expected valid=0000 en=0", ch_rd_valid, bram_en);
        else passed++;
    endtask

    // Pointer sits at 2 on entry, so the rotation starts at channel 2.
    task automatic test_fairness;
        int cnt [NCH];
        int exp_ch;
        for (int k = 0; k < NCH; k++) cnt[k] = 0;
        @(negedge clk);
        for (int k = 0; k < NCH; k++) set_ch(k, 1'b1, 1'b1, 12'h200 + AW'(k), 8'hC0 + DW'(k));
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            exp_ch = (2 + i) % NCH;
            checks++;
            if (ch_gnt !== 4'(1 << exp_ch))
                $display("FAIL fair_gnt[%0d]: got %b expected %b", i, ch_gnt, 4'(1 << exp_ch));
            else passed++;
            for (int k = 0; k < NCH; k++) if (ch_gnt[k]) cnt[k]++;
        end
        for (int k = 0; k < NCH; k++) begin
            checks++;
            if (cnt[k] != 4) $display("FAIL fair_count[%0d]: got %0d expected 4", k, cnt[k]);
            else passed++;
        end
        @(negedge clk);
        ch_req = '0;
    endtask

    task automatic test_pipelined_mix;
        @(negedge clk);
        set_ch(2, 1'b1, 1'b1, 12'h011, 8'h11);
        #1;
        checks++;
        if (ch_gnt !== 4'b0100) $display("FAIL mix_preload_gnt: got %b expected %b", ch_gnt, 4'b0100);
        else passed++;
        @(negedge clk);
        ch_req = '0;
        set_ch(0, 1'b1, 1'b1, 12'h010, 8'hAA);
        #1;
        checks++;
        if (ch_gnt !== 4'b0001) $display("FAIL mix_wr_gnt: got %b expected %b", ch_gnt, 4'b0001);
        else passed++;
        @(negedge clk);
        set_ch(0, 1'b1, 1'b0, 12'h011, 8'h00);
        set_ch(1, 1'b1, 1'b0, 12'h010, 8'h00);
        #1;
        checks++;
        if (ch_gnt !== 4'b0010) $display("FAIL mix_rd1_gnt: got %b expected %b", ch_gnt, 4'b0010);
        else passed++;
        @(negedge clk);
        ch_req[1] = 1'b0;
        #1;
        checks++;
        if (ch_gnt !== 4'b0001) $display("FAIL mix_rd0_gnt: got %b expected %b", ch_gnt, 4'b0001);
        else passed++;
        checks++;
        if ({bram_en, bram_we, bram_addr} !== {1'b1, 1'b0, 12'h010})
            $display("FAIL mix_rd1_cmd: got en=%b we=%b addr=%h expected en=1 we=0 addr=010", bram_en, bram_we, bram_addr);
        else passed++;
        @(negedge clk);
        ch_req = '0;
        checks++;
        if ({bram_en, bram_we, bram_addr} !== {1'b1, 1'b0, 12'h011})
            $display("FAIL mix_rd0_cmd: got en=%b we=%b addr=%h expected en=1 we=0 addr=011", bram_en, bram_we, bram_addr);
        else passed++;
        checks++;
        if (ch_rd_valid !== 4'b0000) $display("FAIL mix_early: got %b expected 0000", ch_rd_valid);
        else passed++;
        @(negedge clk);
        checks++;
        if (ch_rd_valid !== 4'b0010 || ch_rd_data !== 8'hAA)
            $display("FAIL mix_resp1: got valid=%b data=%h expected valid=0010 data=aa", ch_rd_valid, ch_rd_data);
        else passed++;
        @(negedge clk);
        checks++;
        if (ch_rd_valid !== 4'b0001 || ch_rd_data !== 8'h11)
            $display("FAIL mix_resp0: got valid=%b data=%h expected valid=0001 data=11", ch_rd_valid, ch_rd_data);
        else passed++;
        @(negedge clk);
        checks++;
        if (ch_rd_valid !== 4'b0000) $display("FAIL mix_after: got %b expected 0000", ch_rd_valid);
        else passed++;
    endtask

    task automatic test_reset_midflight;
        @(negedge clk);
        set_ch(1, 1'b1, 1'b0, 12'h010, 8'h00);
        #1;
        checks++;
        if (ch_gnt !== 4'b0010) $display("FAIL mid_gnt_a: got %b expected %b", ch_gnt, 4'b0010);
        else passed++;
        @(negedge clk);
        ch_req = '0;
        set_ch(2, 1'b1, 1'b0, 12'h011, 8'h00);
        #1;
        checks++;
        if (ch_gnt !== 4'b0100) $display("FAIL mid_gnt_b: got %b expected %b", ch_gnt, 4'b0100);
        else passed++;
        @(negedge clk);
        ch_req = '0;
        set_ch(3, 1'b1, 1'b0, 12'h000, 8'h00);
        reset = 1'b1;
        #1;
        checks++;
        if (ch_gnt !== 4'b0000) $display("FAIL mid_gnt_in_reset: got %b expected 0000", ch_gnt);
        else passed++;
        checks++;
        if (ch_rd_valid !== 4'b0000) $display("FAIL mid_valid_in_reset: got %b expected 0000", ch_rd_valid);
        else passed++;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) begin
                reset  = 1'b0;
                ch_req = '0;
            end
            checks++;
            if (ch_rd_valid !== 4'b0000) $display("FAIL mid_valid[%0d]: got %b expected 0000", c, ch_rd_valid);
            else passed++;
        end
    endtask

    // Pointer is 0 after the mid-flight reset; a grant to channel 2 moves
    // it to 3, and ten idle cycles must leave it there.
    task automatic test_idle;
        @(negedge clk);
        set_ch(2, 1'b1, 1'b1, 12'h300, 8'h33);
        #1;
        checks++;
        if (ch_gnt !== 4'b0100) $display("FAIL idle_setup_gnt: got %b expected %b", ch_gnt, 4'b0100);
        else passed++;
        @(negedge clk);
        ch_req = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bram_en !== 1'b0 || ch_gnt !== 4'b0000)
                $display("FAIL idle[%0d]: got en=%b gnt=%b expected en=0 gnt=0000", c, bram_en, ch_gnt);
            else passed++;
        end
        @(negedge clk);
        for (int k = 0; k < NCH; k++) set_ch(k, 1'b1, 1'b1, 12'h3F0 + AW'(k), 8'h00);
        #1;
        checks++;
        if (ch_gnt !== 4'b1000) $display("FAIL idle_ptr_kept: got %b expected %b", ch_gnt, 4'b1000);
        else passed++;
        @(negedge clk);
        ch_req = '0;
    endtask

    initial begin
        reset      = 1'b1;
        ch_req     = '0;
        ch_we      = '0;
        ch_addr    = '0;
        ch_wr_data = '0;
        test_reset();
        test_single_read();
        test_fairness();
        test_pipelined_mix();
        test_reset_midflight();
        test_idle();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passed);
        $fatal(1);
    end

endmodule
`default_nettype wire
